// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle add/sub/slt/or/and plus iterative unsigned
// multiply (shift-add) and divide (restoring), one bit per clock.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_t;

  function automatic logic [2:0] decode_op(input logic [1:0] op, input logic [3:0] f);
    logic [2:0] d;
    if (op[1]) begin
      case (f)
        4'b0000: d = OP_ADD;
        4'b0010: d = OP_SUB;
        4'b1010: d = OP_SLT;
        4'b0101: d = OP_OR;
        4'b0100: d = OP_AND;
        4'b1111: d = OP_MUL;
        4'b0111: d = OP_DIV;
        default: d = OP_ADD;
      endcase
    end else if (op[0]) begin
      d = OP_SUB;
    end else begin
      d = OP_ADD;
    end
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] alu_single(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_SUB:  r = x - y;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: r = x + y;
    endcase
    return r;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] acc_hi_r, acc_lo_r, opnd_r;

  logic [2:0]       dec_op_s;
  logic             is_long_s, accept_s, last_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] mul_hi_s, mul_lo_s;
  logic [WIDTH:0]   div_shift_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_rem_s, div_quo_s;
  logic             done_nxt_s, ready_nxt_s;
  logic [WIDTH-1:0] res_nxt_s, hi_nxt_s;

  assign dec_op_s  = decode_op(aluop, funct);
  assign is_long_s = (dec_op_s == OP_MUL) || (dec_op_s == OP_DIV);
  assign accept_s  = start && (state_r == IDLE);
  assign last_s    = (state_r == ITER) && (cnt_r == LAST_CNT);

  // One iteration step of both engines; the accumulator is shared: for mulu
  // {acc_hi, acc_lo} is the partial product, for divu acc_hi is the remainder
  // and acc_lo shifts dividend bits out while quotient bits shift in.
  always_comb begin
    mul_sum_s   = acc_lo_r[0] ? ({1'b0, acc_hi_r} + {1'b0, opnd_r}) : {1'b0, acc_hi_r};
    mul_hi_s    = mul_sum_s[WIDTH:1];
    mul_lo_s    = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
    div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_ge_s    = div_shift_s >= {1'b0, opnd_r};
    div_rem_s   = div_ge_s ? (div_shift_s[WIDTH-1:0] - opnd_r) : div_shift_s[WIDTH-1:0];
    div_quo_s   = {acc_lo_r[WIDTH-2:0], div_ge_s};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && is_long_s) begin
          state_nxt_s = ITER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ITER: begin
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ITER;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: next values of the registered result bus and handshake
  always_comb begin
    done_nxt_s  = 1'b0;
    res_nxt_s   = result;
    hi_nxt_s    = result_hi;
    ready_nxt_s = (state_nxt_s == IDLE);
    case (state_r)
      IDLE: begin
        if (accept_s && !is_long_s) begin
          done_nxt_s = 1'b1;
          res_nxt_s  = alu_single(dec_op_s, a, b);
          hi_nxt_s   = '0;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      ITER: begin
        if (last_s) begin
          done_nxt_s = 1'b1;
          if (op_r == OP_MUL) begin
            res_nxt_s = mul_lo_s;
            hi_nxt_s  = mul_hi_s;
          end else begin
            res_nxt_s = div_quo_s;
            hi_nxt_s  = div_rem_s;
          end
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready     <= 1'b1;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
    end else begin
      ready     <= ready_nxt_s;
      done      <= done_nxt_s;
      result    <= res_nxt_s;
      result_hi <= hi_nxt_s;
      zero      <= (res_nxt_s == '0);
    end
  end

  // Operand capture, iteration counter and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= OP_ADD;
      cnt_r    <= '0;
      acc_hi_r <= '0;
      acc_lo_r <= '0;
      opnd_r   <= '0;
    end else if (accept_s) begin
      op_r     <= dec_op_s;
      cnt_r    <= '0;
      acc_hi_r <= '0;
      if (dec_op_s == OP_MUL) begin
        acc_lo_r <= b;
        opnd_r   <= a;
      end else begin
        acc_lo_r <= a;
        opnd_r   <= b;
      end
    end else if (state_r == ITER) begin
      cnt_r <= cnt_r + CW'(1);
      if (op_r == OP_MUL) begin
        acc_hi_r <= mul_hi_s;
        acc_lo_r <= mul_lo_s;
      end else begin
        acc_hi_r <= div_rem_s;
        acc_lo_r <= div_quo_s;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: driver pushes model results, monitor pops on done.
module tb_alu_iter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   aluop = 2'b00;
  logic [3:0]   funct = 4'b0000;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, done, zero;
  logic [W-1:0] result, result_hi;

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .ready(ready), .done(done), .result(result),
    .result_hi(result_hi), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] res; logic [W-1:0] hi; int due; } exp_t;
  exp_t exp_q[$];
  int   cyc = 0;
  int   busy_until = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: decode straight from the opcode table, compute with plain arithmetic
  task automatic model(input logic [1:0] op, input logic [3:0] f,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [W-1:0] h, output bit long_op);
    string kind;
    logic [2*W-1:0] p;
    kind = "add";
    if (op[1]) begin
      if (f == 4'b0010) kind = "sub";
      else if (f == 4'b1010) kind = "slt";
      else if (f == 4'b0101) kind = "or";
      else if (f == 4'b0100) kind = "and";
      else if (f == 4'b1111) kind = "mul";
      else if (f == 4'b0111) kind = "div";
      else kind = "add";
    end else if (op[0]) kind = "sub";
    h = '0;
    long_op = (kind == "mul") || (kind == "div");
    if (kind == "sub") r = x - y;
    else if (kind == "slt") r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
    else if (kind == "or") r = x | y;
    else if (kind == "and") r = x & y;
    else if (kind == "mul") begin
      p = (2*W)'(x) * (2*W)'(y);
      r = p[W-1:0];
      h = p[2*W-1:W];
    end else if (kind == "div") begin
      if (y == '0) begin r = '1; h = x; end
      else begin r = x / y; h = x % y; end
    end else r = x + y;
  endtask

  // Waits (optionally with start held high and junk operands) until idle, then issues
  task automatic issue(input logic [1:0] op, input logic [3:0] f,
                       input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    exp_t e;
    bit   lng;
    @(negedge clk);
    while (cyc < busy_until) begin
      start = hold;
      aluop = 2'($urandom); funct = 4'($urandom);
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
    end
    start = 1'b1; aluop = op; funct = f; a = x; b = y;
    model(op, f, x, y, e.res, e.hi, lng);
    e.due = cyc + 1 + (lng ? W : 0);
    busy_until = lng ? e.due : cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic idle_wait();
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3 * W && exp_q.size() > 0; i++) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_result"}, result, '0);
    chk({tag, "_result_hi"}, result_hi, '0);
    chk({tag, "_zero"}, W'(zero), W'(1));
    chk({tag, "_ready"}, W'(ready), W'(1));
    chk({tag, "_done"}, W'(done), W'(0));
  endtask

  // Monitor: ready against the bench's busy window, results popped on done
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        chk("ready", W'(ready), W'(cyc >= busy_until));
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", W'(done), W'(0));
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (cyc != e.due) begin
              errors++;
              $display("FAIL done_cycle: got %0d expected %0d", cyc, e.due);
            end
            chk("result", result, e.res);
            chk("result_hi", result_hi, e.hi);
            chk("zero", W'(zero), W'(e.res == '0));
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL done_timeout: no done by cycle %0d expected at %0d", cyc, e.due);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'b10, 4'b0010, W'(5), W'(7), 1'b0);
    issue(2'b10, 4'b1010, W'(8'hFF), W'(1), 1'b0);
    issue(2'b00, 4'b1010, W'(8'hFF), W'(1), 1'b0);
    issue(2'b01, 4'b1010, W'(9), W'(9), 1'b0);
    issue(2'b11, 4'b0001, W'(3), W'(4), 1'b0);
    issue(2'b10, 4'b0101, W'(8'hA0), W'(8'h05), 1'b0);
    issue(2'b10, 4'b0100, W'(8'hF0), W'(8'h3C), 1'b0);
    issue(2'b10, 4'b1111, W'(8'hFF), W'(8'hFF), 1'b0);
    issue(2'b10, 4'b0000, W'(1), W'(2), 1'b1);
    issue(2'b10, 4'b0111, W'(200), W'(7), 1'b1);
    issue(2'b10, 4'b0111, W'(13), W'(0), 1'b1);
    issue(2'b10, 4'b1111, W'(8'h80), W'(8'h02), 1'b1);
    idle_wait();

    // Reset in the middle of a multiply: no done, outputs cleared at once
    issue(2'b10, 4'b1111, W'(8'h37), W'(8'h5A), 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    busy_until = 0;
    #1 check_reset_outputs("mid_iter_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b10, 4'b0000, W'(8'h10), W'(8'h22), 1'b0);

    // Back-to-back: add, divu, or with start held high throughout
    issue(2'b10, 4'b0000, W'(8'h7F), W'(8'h81), 1'b1);
    issue(2'b10, 4'b0111, W'(8'hFE), W'(8'h10), 1'b1);
    issue(2'b10, 4'b0101, W'(8'h0F), W'(8'h30), 1'b1);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] f;
      int sel;
      sel = int'($urandom_range(0, 8));
      case (sel)
        0: f = 4'b0000; 1: f = 4'b0010; 2: f = 4'b1010; 3: f = 4'b0101;
        4: f = 4'b0100; 5: f = 4'b1111; 6: f = 4'b0111;
        default: f = 4'($urandom);
      endcase
      issue(2'($urandom), f, W'($urandom), ($urandom_range(0, 9) == 0) ? '0 : W'($urandom),
            1'($urandom));
    end
    idle_wait();
    repeat (2) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d results never seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end
endmodule
